// File: rtl/mbus_tx_framer_if.sv
// ----------------------------------------------------------------------------
// mbus_tx_framer_if
// Bus bundle between the MBUS transmit-frame builder and its surroundings.
//   Memory read port : rd_en, rd_sel (0=LDUB 1=LCUCB 2=LCUDB), rd_addr, rd_data
//   TX buffer port   : tx_buf_wren, tx_buf_waddr, tx_buf_wdata
//   Frame completion : tx_data_len, tx_start
// Modports:
//   master - the framer (drives reads and buffer writes, receives rd_data)
//   slave  - memory/buffer side (returns rd_data)
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
interface mbus_tx_framer_if #(
    parameter int AW     = 24,
    parameter int BUF_AW = 11
);
    logic              rd_en;
    logic [1:0]        rd_sel;
    logic [AW-1:0]     rd_addr;
    logic [7:0]        rd_data;
    logic              tx_buf_wren;
    logic [BUF_AW-1:0] tx_buf_waddr;
    logic [7:0]        tx_buf_wdata;
    logic [BUF_AW-1:0] tx_data_len;
    logic              tx_start;

    modport master (
        output rd_en, rd_sel, rd_addr,
        input  rd_data,
        output tx_buf_wren, tx_buf_waddr, tx_buf_wdata,
        output tx_data_len, tx_start
    );

    modport slave (
        input  rd_en, rd_sel, rd_addr,
        output rd_data,
        input  tx_buf_wren, tx_buf_waddr, tx_buf_wdata,
        input  tx_data_len, tx_start
    );
endinterface

// File: rtl/mbus_tx_framer.sv
// ----------------------------------------------------------------------------
// mbus_tx_framer
// MBUS transmit-frame builder. On each accepted request it writes a 4-byte
// header (DA, SA, FC, mode), CMD_LEN command bytes, the card type byte and
// PAYLOAD_LEN payload bytes into the TX buffer, then pulses tx_start.
// Command/payload bytes come from one shared pipelined read port with a
// latency of RD_LAT cycles.
//
// Optional feature: define MBUS_TX_CSUM_EN to append an XOR checksum byte
// after the payload (frame length grows by one).
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   i_ini_done        init complete; rising edge snapshots rack/slot
//   i_rack_id/slot_id rack and slot numbers
//   i_req             1-cycle frame request
//   i_req_mode/addr   mode byte and base address, sampled with i_req
//   o_busy            frame build in progress
//   o_req_drop        1-cycle pulse: request ignored because busy
//   bus               memory read port, TX buffer port, tx_start/tx_data_len
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module mbus_tx_framer #(
    parameter int          AW          = 24,
    parameter int          BUF_AW      = 11,
    parameter int          CMD_LEN     = 5,
    parameter int          PAYLOAD_LEN = 128,
    parameter int          RD_LAT      = 2,
    parameter logic [7:0]  DA_VAL      = 8'hFE,
    parameter logic [7:0]  FC_VAL      = 8'h20,
    parameter logic [7:0]  TYPE_VAL    = 8'h60,
    parameter logic [7:0]  DL_MODE     = 8'h02
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_ini_done,
    input  logic [2:0]    i_rack_id,
    input  logic [3:0]    i_slot_id,
    input  logic          i_req,
    input  logic [7:0]    i_req_mode,
    input  logic [AW-1:0] i_req_addr,
    output logic          o_busy,
    output logic          o_req_drop,
    mbus_tx_framer_if.master bus
);

    localparam int MAX_LEN = (CMD_LEN > PAYLOAD_LEN) ? CMD_LEN : PAYLOAD_LEN;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);

    localparam logic [CNT_W-1:0] CMD_CNT   = CNT_W'(CMD_LEN);
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_LEN - 1);
    localparam logic [CNT_W-1:0] PAY_CNT   = CNT_W'(PAYLOAD_LEN);
    localparam logic [CNT_W-1:0] PAY_LAST  = CNT_W'(PAYLOAD_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [AW-1:0]    AW_ONE    = AW'(1);
    localparam logic [AW-1:0]    DL_DATA_A = AW'(8);
    localparam logic [BUF_AW-1:0] BUF_ONE  = BUF_AW'(1);
`ifdef MBUS_TX_CSUM_EN
    localparam logic [BUF_AW-1:0] FRAME_LEN = BUF_AW'(6 + CMD_LEN + PAYLOAD_LEN);
`else
    localparam logic [BUF_AW-1:0] FRAME_LEN = BUF_AW'(5 + CMD_LEN + PAYLOAD_LEN);
`endif

    typedef enum logic [2:0] {
        S_WAIT_INI,
        S_READY,
        S_HDR,
        S_CMD,
        S_TYPE,
        S_DATA,
`ifdef MBUS_TX_CSUM_EN
        S_CSUM,
`endif
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic               r_ini_d;
    logic [2:0]         r_rack;
    logic [3:0]         r_slot;
    logic [7:0]         r_sa;
    logic [7:0]         r_mode;
    logic [AW-1:0]      r_addr;
    logic [AW-1:0]      r_rd_addr;
    logic [CNT_W-1:0]   r_issue_cnt;
    logic [CNT_W-1:0]   r_wr_cnt;
    logic [BUF_AW-1:0]  r_waddr;
    logic [BUF_AW-1:0]  r_len;
    // Bit k set: a read issued k+1 cycles ago is in flight. Reads return in
    // issue order, so the buffer address is simply the running r_waddr.
    logic [RD_LAT-1:0]  r_vld;
`ifdef MBUS_TX_CSUM_EN
    logic [7:0]         r_csum;
`endif

    logic               w_ini_rise;
    logic               w_dl;
    logic [7:0]         w_sa;
    logic               w_pipe_wr;
    logic               w_accept;
    logic               w_rd_en;
    logic [1:0]         w_rd_sel;
    logic [AW-1:0]      w_rd_addr;
    logic               w_wren;
    logic [BUF_AW-1:0]  w_waddr;
    logic [7:0]         w_wdata;
    logic               w_tx_start;
    logic               w_busy;
    logic               w_req_drop;

    assign w_ini_rise = i_ini_done & ~r_ini_d;
    assign w_dl       = (r_mode == DL_MODE);
    // SA = rack*14 + 14 - slot, deliberately kept to 8 bits with wrap.
    assign w_sa       = ({5'b0, r_rack} * 8'd14) + 8'd14 - {4'b0, r_slot};
    assign w_pipe_wr  = r_vld[RD_LAT-1];

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_rd_en      = 1'b0;
        w_rd_sel     = 2'd0;
        w_rd_addr    = '0;
        w_wren       = 1'b0;
        w_waddr      = '0;
        w_wdata      = 8'h00;
        w_tx_start   = 1'b0;
        w_busy       = 1'b0;

        // Returning read data; only ever in flight during CMD and DATA.
        if (w_pipe_wr) begin
            w_wren  = 1'b1;
            w_waddr = r_waddr;
            w_wdata = bus.rd_data;
        end

        case (r_state)
            S_WAIT_INI: begin
                if (w_ini_rise) w_state_next = S_READY;
            end
            S_READY: begin
                if (i_req) begin
                    w_accept     = 1'b1;
                    w_state_next = S_HDR;
                end
            end
            S_HDR: begin
                w_busy  = 1'b1;
                w_wren  = 1'b1;
                w_waddr = r_waddr;
                case (r_waddr[1:0])
                    2'd0:    w_wdata = DA_VAL;
                    2'd1:    w_wdata = r_sa;
                    2'd2:    w_wdata = FC_VAL;
                    default: w_wdata = r_mode;
                endcase
                if (r_waddr[1:0] == 2'd3) w_state_next = S_CMD;
            end
            S_CMD: begin
                w_busy = 1'b1;
                if (r_issue_cnt < CMD_CNT) begin
                    w_rd_en   = 1'b1;
                    w_rd_sel  = w_dl ? 2'd0 : 2'd1;
                    w_rd_addr = r_rd_addr;
                end
                // Leave only once the last command byte has landed, so the
                // type byte follows it directly and DATA starts with an empty pipe.
                if (w_pipe_wr && (r_wr_cnt == CMD_LAST)) w_state_next = S_TYPE;
            end
            S_TYPE: begin
                w_busy       = 1'b1;
                w_wren       = 1'b1;
                w_waddr      = r_waddr;
                w_wdata      = TYPE_VAL;
                w_state_next = S_DATA;
            end
            S_DATA: begin
                w_busy = 1'b1;
                if (r_issue_cnt < PAY_CNT) begin
                    w_rd_en   = 1'b1;
                    w_rd_sel  = w_dl ? 2'd0 : 2'd2;
                    w_rd_addr = r_rd_addr;
                end
                if (w_pipe_wr && (r_wr_cnt == PAY_LAST)) begin
`ifdef MBUS_TX_CSUM_EN
                    w_state_next = S_CSUM;
`else
                    w_state_next = S_DONE;
`endif
                end
            end
`ifdef MBUS_TX_CSUM_EN
            S_CSUM: begin
                w_busy       = 1'b1;
                w_wren       = 1'b1;
                w_waddr      = r_waddr;
                w_wdata      = r_csum;
                w_state_next = S_DONE;
            end
`endif
            S_DONE: begin
                w_busy     = 1'b1;
                w_tx_start = 1'b1;
                // A request coinciding with tx_start starts the next frame.
                if (i_req) begin
                    w_accept     = 1'b1;
                    w_state_next = S_HDR;
                end else begin
                    w_state_next = S_READY;
                end
            end
            default: w_state_next = S_WAIT_INI;
        endcase
    end

    assign w_req_drop = i_req & w_busy & ~w_accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld <= '0;
        end else begin
            for (int k = RD_LAT - 1; k > 0; k--) r_vld[k] <= r_vld[k-1];
            r_vld[0] <= w_rd_en;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_WAIT_INI;
            r_ini_d     <= 1'b0;
            r_rack      <= '0;
            r_slot      <= '0;
            r_sa        <= '0;
            r_mode      <= '0;
            r_addr      <= '0;
            r_rd_addr   <= '0;
            r_issue_cnt <= '0;
            r_wr_cnt    <= '0;
            r_waddr     <= '0;
            r_len       <= '0;
`ifdef MBUS_TX_CSUM_EN
            r_csum      <= '0;
`endif
        end else begin
            r_state <= w_state_next;
            r_ini_d <= i_ini_done;

            if (w_ini_rise) begin
                r_rack <= i_rack_id;
                r_slot <= i_slot_id;
            end

            if (w_wren)    r_waddr <= r_waddr + BUF_ONE;
            if (w_pipe_wr) r_wr_cnt <= r_wr_cnt + CNT_ONE;
            if (w_rd_en) begin
                r_rd_addr   <= r_rd_addr + AW_ONE;
                r_issue_cnt <= r_issue_cnt + CNT_ONE;
            end

            // Arm the command read phase on the last header byte.
            if ((r_state == S_HDR) && (r_waddr[1:0] == 2'd3)) begin
                r_rd_addr   <= w_dl ? '0 : (r_addr >> 4);
                r_issue_cnt <= '0;
                r_wr_cnt    <= '0;
            end

            // Arm the payload read phase while the type byte is written.
            if (r_state == S_TYPE) begin
                r_rd_addr   <= w_dl ? DL_DATA_A : r_addr;
                r_issue_cnt <= '0;
                r_wr_cnt    <= '0;
            end

            if (w_state_next == S_DONE) r_len <= FRAME_LEN;

`ifdef MBUS_TX_CSUM_EN
            if (w_wren && (r_state != S_CSUM)) r_csum <= r_csum ^ w_wdata;
`endif

            if (w_accept) begin
                r_mode  <= i_req_mode;
                r_addr  <= i_req_addr;
                r_sa    <= w_sa;
                r_waddr <= '0;
`ifdef MBUS_TX_CSUM_EN
                r_csum  <= '0;
`endif
            end
        end
    end

    assign bus.rd_en        = w_rd_en;
    assign bus.rd_sel       = w_rd_sel;
    assign bus.rd_addr      = w_rd_addr;
    assign bus.tx_buf_wren  = w_wren;
    assign bus.tx_buf_waddr = w_waddr;
    assign bus.tx_buf_wdata = w_wdata;
    assign bus.tx_start     = w_tx_start;
    assign bus.tx_data_len  = r_len;
    assign o_busy           = w_busy;
    assign o_req_drop       = w_req_drop;

endmodule
